// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and helpers for the iterative round sequencer.
// State layout: packed [15:0][7:0], byte 15-4r-c holds row r, column c.
package aes_pkg;

    typedef logic [15:0][7:0] state_t;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic int idx(input int r, input int c);
        return 15 - 4 * r - c;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t rk,
    input  logic   bypass_mix,
    output state_t next
);

    state_t sub;
    state_t shifted;
    state_t mixed;

    // Row r rotates left by r, so output column c takes input column c+r.
    always_comb begin
        sub     = '0;
        shifted = '0;
        for (int i = 0; i < 16; i++) begin
            sub[i] = SBOX[state[i]];
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[idx(r, c)] = sub[idx(r, (c + r) % 4)];
            end
        end
    end

    mixColumns u_mix (
        .data   (shifted),
        .result (mixed)
    );

    assign next = (bypass_mix ? shifted : mixed) ^ rk;

endmodule

// File: rtl/mixColumns.sv
// AES MixColumns over the row-major state: each column multiplied by the
// circulant {02,03,01,01} matrix in GF(2^8) mod 0x11B.
module mixColumns
    import aes_pkg::*;
(
    input  state_t data,
    output state_t result
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        result = '0;
        for (int c = 0; c < 4; c++) begin
            result[idx(0, c)] = xtime(data[idx(0, c)]) ^ xtime(data[idx(1, c)]) ^ data[idx(1, c)]
                              ^ data[idx(2, c)] ^ data[idx(3, c)];
            result[idx(1, c)] = data[idx(0, c)] ^ xtime(data[idx(1, c)]) ^ xtime(data[idx(2, c)])
                              ^ data[idx(2, c)] ^ data[idx(3, c)];
            result[idx(2, c)] = data[idx(0, c)] ^ data[idx(1, c)] ^ xtime(data[idx(2, c)])
                              ^ xtime(data[idx(3, c)]) ^ data[idx(3, c)];
            result[idx(3, c)] = xtime(data[idx(0, c)]) ^ data[idx(0, c)] ^ data[idx(1, c)]
                              ^ data[idx(2, c)] ^ xtime(data[idx(3, c)]);
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: one round per clock through a shared
// round datapath, round keys fetched combinationally from an external key store.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int RK_AW      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     plaintext,
    output logic [RK_AW-1:0] rk_addr,
    input  logic [127:0]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     ciphertext,
    output logic             busy,
    output logic [3:0]       round
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_MID_ROUND = 4'(NUM_ROUNDS - 1);

    fsm_t       fsm_q, fsm_d;
    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    state_t     ct_q, ct_d;
    logic       valid_q, valid_d;
    logic       bypass;
    state_t     rk;
    state_t     round_next;

    assign rk = rk_data;

    aes_round_comb u_round (
        .state      (state_q),
        .rk         (rk),
        .bypass_mix (bypass),
        .next       (round_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            ct_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            ct_q    <= ct_d;
            valid_q <= valid_d;
        end
    end

    // A new block can be loaded from IDLE, or from DONE on the very edge the
    // previous result is taken; loading always applies round key 0.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        round_d  = round_q;
        ct_d     = ct_q;
        valid_d  = valid_q;
        in_ready = 1'b0;
        rk_addr  = '0;
        bypass   = 1'b0;
        busy     = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = plaintext ^ rk_data;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                busy    = 1'b1;
                rk_addr = RK_AW'(round_q);
                state_d = round_next;
                round_d = round_q + 4'd1;
                if (round_q == LAST_MID_ROUND) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                busy    = 1'b1;
                bypass  = 1'b1;
                rk_addr = RK_AW'(round_q);
                ct_d    = round_next;
                valid_d = 1'b1;
                round_d = 4'd0;
                fsm_d   = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (in_valid) begin
                        state_d = plaintext ^ rk_data;
                        round_d = 4'd1;
                        fsm_d   = ROUND;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign out_valid  = valid_q;
    assign ciphertext = ct_q;
    assign round      = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: transaction-level AES reference model with its own key
// expansion and S-box derivation, compared against the sequencer every cycle.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic         in_ready;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         out_valid;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round;

    logic [127:0] rk_store [0:15];
    logic [127:0] cur_key = '0;
    logic [7:0]   sbox_m [0:255];
    int           n_checks = 0;
    int           n_fail = 0;

    aes_pkg::state_t mc_state;
    aes_pkg::state_t mc_rk;
    aes_pkg::state_t mc_next;
    logic            mc_bypass;

    always #5 clk = ~clk;

    always_comb rk_data = rk_store[rk_addr];

    aes_round_sequencer #(.NUM_ROUNDS(10), .RK_AW(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round      (round)
    );

    aes_round_comb u_mc (
        .state      (mc_state),
        .rk         (mc_rk),
        .bypass_mix (mc_bypass),
        .next       (mc_next)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from first principles: multiplicative inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] inv_sbox(input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int x = 0; x < 256; x++) begin
            if (sbox_m[x] == v) r = 8'(x);
        end
        return r;
    endfunction

    // FIPS byte order (column-major) to the row-major packed layout; self-inverse.
    function automatic logic [127:0] transpose(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                y[8*(15-4*r-c) +: 8] = x[127-8*(r+4*c) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Textbook AES-128 on a FIPS-ordered byte array s[r+4c].
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] res;
        rk = round_key(key, 0);
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[127-8*k -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox_m[s[k]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            rk = round_key(key, rnd);
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[127-8*k -: 8];
        end
        res = '0;
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // Transaction model: a block accepted when the sequencer is free takes ten
    // edges to compute, then is held until the consumer takes it.
    bit           m_active = 0;
    bit           m_holding = 0;
    int           m_age = 0;
    logic [127:0] m_ct = '0;
    logic [127:0] m_pending = '0;

    always @(posedge clk or negedge reset_n) begin
        bit accept;
        if (!reset_n) begin
            m_active  = 0;
            m_holding = 0;
            m_age     = 0;
            m_ct      = '0;
        end else begin
            accept = in_valid && !m_active && (!m_holding || out_ready);
            if (m_holding && out_ready) m_holding = 0;
            if (m_active) begin
                m_age++;
                if (m_age == 10) begin
                    m_active  = 0;
                    m_holding = 1;
                    m_ct      = m_pending;
                end
            end else if (accept) begin
                m_active  = 1;
                m_age     = 0;
                m_pending = transpose(model_encrypt(transpose(plaintext), cur_key));
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_round;
        if (reset_n) begin
            exp_round = m_active ? 4'(m_age + 1) : 4'd0;
            checkOutput("cyc_out_valid", 128'(out_valid), 128'(m_holding));
            checkOutput("cyc_busy", 128'(busy), 128'(m_active));
            checkOutput("cyc_round", 128'(round), 128'(exp_round));
            checkOutput("cyc_rk_addr", 128'(rk_addr), 128'(exp_round));
            checkOutput("cyc_in_ready", 128'(in_ready), 128'(!m_active && (!m_holding || out_ready)));
            checkOutput("cyc_ciphertext", ciphertext, m_ct);
        end
    end

    task automatic load_key(input logic [127:0] key);
        cur_key = key;
        for (int i = 0; i < 16; i++) rk_store[i] = (i <= 10) ? transpose(round_key(key, i)) : '0;
    endtask

    // Offers a block from posedge+1 and returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [127:0] pt);
        logic accepted;
        accepted  = 1'b0;
        plaintext = transpose(pt);
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            if (accepted) checkOutput("rk_addr_at_load", 128'(rk_addr), 128'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("accepted", 128'(accepted), 128'd1);
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid is visible.
    task automatic wait_result(output int edges_incl, output int busy_cycles);
        logic seen;
        seen        = 1'b0;
        edges_incl  = 1;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                checkOutput("rk_addr_seq", 128'(rk_addr), 128'(edges_incl));
                @(posedge clk);
                #1;
                edges_incl++;
            end
        end
        checkOutput("result_seen", 128'(seen), 128'd1);
    endtask

    task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] ct);
        int e;
        int b;
        load_key(key);
        applyStimulus(pt);
        wait_result(e, b);
        checkOutput({name, "_latency"}, 128'(e), 128'd11);
        checkOutput({name, "_busy_cycles"}, 128'(b), 128'd10);
        checkOutput(name, ciphertext, transpose(ct));
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [127:0] exp2;
        int           e;
        int           seen_cnt;
        logic         hit;

        build_sbox();
        checkOutput("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
        checkOutput("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
        checkOutput("model_rk10", round_key(KEY_B, 10), RK10_B);
        checkOutput("model_ct_b", model_encrypt(PT_B, KEY_B), CT_B);
        checkOutput("model_ct_c", model_encrypt(PT_C, KEY_C), CT_C);

        // Column 0 after SubBytes/ShiftRows becomes db,13,53,45.
        mc_state     = '0;
        mc_state[15] = inv_sbox(8'hdb);
        mc_state[10] = inv_sbox(8'h13);
        mc_state[5]  = inv_sbox(8'h53);
        mc_state[0]  = inv_sbox(8'h45);
        mc_rk        = '0;
        mc_bypass    = 1'b0;
        #1;
        checkOutput("mix_col0", 128'({mc_next[15], mc_next[11], mc_next[7], mc_next[3]}), 128'h8e4da1bc);
        mc_bypass = 1'b1;
        #1;
        checkOutput("bypass_col0", 128'({mc_next[15], mc_next[11], mc_next[7], mc_next[3]}), 128'hdb135345);

        load_key(KEY_B);
        #10;
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_round", 128'(round), 128'd0);
        checkOutput("reset_ciphertext", ciphertext, 128'd0);
        checkOutput("reset_rk_addr", 128'(rk_addr), 128'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;

        run_block("ct_appendix_b", PT_B, KEY_B, CT_B);
        consume();
        run_block("ct_zero", 128'd0, 128'd0, CT_Z);
        consume();

        // Backpressure: result held, in_ready low, offered blocks ignored.
        run_block("ct_appendix_c", PT_C, KEY_C, CT_C);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid  = (i == 1 || i == 3);
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
            checkOutput("bp_ciphertext", ciphertext, transpose(CT_C));
            checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
        end
        consume();
        run_block("ct_after_backpressure", PT_B, KEY_B, CT_B);
        consume();

        // Back-to-back with in_valid and out_ready held high.
        load_key(KEY_B);
        exp2      = transpose(model_encrypt(PT_C, KEY_B));
        out_ready = 1'b1;
        applyStimulus(PT_B);
        plaintext = transpose(PT_C);
        in_valid  = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            hit = out_valid;
            if (!hit) begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("b2b_first_seen", 128'(hit), 128'd1);
        checkOutput("b2b_first_ct", ciphertext, transpose(CT_B));
        checkOutput("b2b_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = 1;
        @(negedge clk);
        checkOutput("b2b_same_edge_busy", 128'(busy), 128'd1);
        checkOutput("b2b_same_edge_round", 128'(round), 128'd1);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (out_valid) begin
                hit = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                e++;
                @(negedge clk);
            end
        end
        checkOutput("b2b_second_gap", 128'(e), 128'd11);
        checkOutput("b2b_second_ct", ciphertext, exp2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while round 5 is in flight.
        load_key(KEY_B);
        applyStimulus(PT_C);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            hit = (round == 4'd5);
        end
        checkOutput("reached_round5", 128'(hit), 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_round", 128'(round), 128'd0);
        checkOutput("abort_ciphertext", ciphertext, 128'd0);
        checkOutput("abort_in_ready", 128'(in_ready), 128'd1);
        checkOutput("abort_rk_addr", 128'(rk_addr), 128'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        seen_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen_cnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("abort_no_result", 128'(seen_cnt), 128'd0);
        run_block("ct_after_reset", PT_B, KEY_B, CT_B);
        consume();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
